uart_tx: RTL
============

# uart_tx

UART transmitter that serialises bytes onto the `tx` line as 8N1 (optionally 8E1/8O1) frames at a parameterised baud rate. It is the transmit-side counterpart of the board's UART receive path and sends gyroscope/rotation data from the FPGA to the host. Bytes are loaded through a valid/ready handshake. Each frame is shifted out LSB-first with start, optional parity, and stop bits.

## Interface
- `CLK_FREQ`, 100_000_000, clock frequency in Hz
- `BAUD_RATE`, 115200, line rate in bit/s
- `STOP_BITS`, 1, number of stop bits; legal values are 1 or 2
- `PARITY_ODD`, 0, 1 = odd parity, 0 = even parity; ignored unless `UART_TX_PARITY_EN` is defined
- `clk`  input  1  system clock; all logic is on its rising edge
- `rst`  input  1  reset, synchronous and active-high
- `data_in`  input  8  byte to send; sampled on the handshake cycle
- `valid`  input  1  `data_in` is valid
- `ready`  output  1  transmitter can accept a byte
- `tx`  output  1  serial line; idles high
- `busy`  output  1  frame in progress; equals `!ready`

## Operation
- BIT_PERIOD = CLK_FREQ / BAUD_RATE, using integer division (truncated). BIT_PERIOD must be ≥ 2; an elaboration-time check enforces this.
- Reset values: `tx`=1, `ready`=1, `busy`=0. All counters are 0. State is IDLE.
- The FSM has five states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx`=1, `ready`=1.
  - On `valid && ready`, latch `data_in` into the shift register and go to START.
  - `valid` without `ready` has no effect. `data_in` is don't-care outside the handshake.
- START: drive `tx`=0 for BIT_PERIOD cycles, then go to DATA with bit index 0.
- DATA:
  - Drive shift-register bit 0 for BIT_PERIOD cycles, then shift right and increment the index.
  - After index 7 completes, go to PARITY (macro defined) or STOP (macro not defined).
- PARITY: drive the parity bit for BIT_PERIOD cycles, then go to STOP.
- STOP:
  - Drive `tx`=1 for STOP_BITS×BIT_PERIOD cycles, then go to IDLE.
- Bit-period counter:
  - Width is $clog2(BIT_PERIOD).
  - Counts 0..BIT_PERIOD-1.
  - Reloads to 0 on every state or bit transition.
  - Wrap-around beyond BIT_PERIOD-1 never occurs.
- `tx` is driven from a flop; it has no combinational path from the inputs.
- `rst` asserted mid-frame aborts the frame. On the next edge `tx`=1 and `ready`=1. No partial frame resumes after reset.
- `valid` held high continuously: consecutive bytes are sent with no idle gap. The next start bit immediately follows the last stop bit.

## Timing
- Handshake on edge k: `ready`=0 and `tx`=0 from cycle k+1.
- FRAME_BITS = 1 + 8 + P + STOP_BITS, where P is 1 with parity enabled and 0 otherwise.
- `tx` holds each bit for exactly BIT_PERIOD cycles.
- `ready` returns to 1 in cycle k+1+FRAME_BITS×BIT_PERIOD. A new handshake may complete in that same cycle.
- Throughput: one byte per FRAME_BITS×BIT_PERIOD cycles.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - The PARITY state is compiled in and inserted between D7 and STOP.
  - Parity bit = ^data XOR PARITY_ODD, so even parity makes the total count of ones, including the parity bit, even.
  - FRAME_BITS includes the parity bit.
- Undefined:
  - The PARITY state, parity logic, and parity register are absent.
  - Frame is 8N1 (or 8N2 with STOP_BITS=2).
  - PARITY_ODD has no effect.

## Structure
- Package `uart_pkg` holds:
  - the `uart_tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - the `bit_period(clk_freq, baud)` function;
  - the data-width constant `UART_DATA_W = 8`.
  - The receive path shares this package.
- Sub-module `uart_baud_gen`:
  - Purpose: bit-period counter that emits a one-cycle `bit_done` pulse at count BIT_PERIOD-1.
  - Synchronous `restart` input.
  - Parameterised by BIT_PERIOD.
- The FSM and shift register stay in `uart_tx`.

## Test plan
All scenarios use CLK_FREQ=1_000_000 and BAUD_RATE=100_000, giving BIT_PERIOD=10.
- **Reset values:** assert `rst` for 3 cycles → `tx`=1, `ready`=1, `busy`=0 during and after reset.
- **Single byte:** send 0xA5 (no parity) → line samples at mid-bit read 0,1,0,1,0,0,1,0,1,1. `ready` returns to 1 exactly 100 cycles after the handshake edge +1.
- **Back-to-back bytes:** hold `valid` high with 0x00 then 0xFF → no idle cycle between the first stop bit and the second start bit. Total time is 200 cycles.
- **Reset mid-frame:** assert `rst` during bit 3 of 0x3C → `tx`=1 and `ready`=1 on the next edge. The next byte, 0x81, transmits as a clean full frame.
- **Parity:** with the macro defined, send 0x07 with PARITY_ODD=0 → parity bit 1. Send 0x07 with PARITY_ODD=1 → parity bit 0. Frame is 110 cycles.
- **STOP_BITS=2:** send 0x55 → `tx` is high for 20 cycles after D7. `ready` returns at cycle k+111.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths: FSM state
// encoding, data width and the bit-period helper.
// No ports; imported with import uart_pkg::*.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Clock cycles per bit, truncated.
  function automatic int bit_period(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BIT_PERIOD-1 and pulses bit_done on the last count.
// Ports: clk, rst (sync, active-high), restart (sync clear to 0), bit_done (comb pulse).
// Wraps to 0 after bit_done, so each bit boundary reloads without an explicit restart.
module uart_baud_gen #(
  parameter int BIT_PERIOD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int CNT_W = $clog2(BIT_PERIOD);

  logic [CNT_W-1:0] cnt;

  assign bit_done = (cnt == CNT_W'(BIT_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 frames, LSB first, with optional parity (macro UART_TX_PARITY_EN).
// Ports: clk, rst (sync, active-high), data_in/valid/ready handshake, tx line (idles high), busy = !ready.
// ready also rises in the final stop-bit cycle so a held valid chains frames with no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] data_in,
  input  logic                   valid,
  output logic                   ready,
  output logic                   tx,
  output logic                   busy
);

  localparam int BIT_PERIOD = bit_period(CLK_FREQ, BAUD_RATE);

  if (BIT_PERIOD < 2) begin : g_bad_bit_period
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  uart_tx_state_t         state_q, state_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0]             idx_q, idx_d;
  logic                   stop_q, stop_d;
  logic                   tx_q, tx_d;
  logic                   bit_done;
  logic                   restart;
  logic                   stop_last;
  logic                   ready_c;
  logic                   accept;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  // Counter is held at 0 while idle; every later transition lands on bit_done,
  // where the counter wraps to 0 by itself.
  assign restart = (state_q == IDLE);

  uart_baud_gen #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .bit_done(bit_done)
  );

  assign stop_last = (state_q == STOP) && bit_done && (stop_q == 1'(STOP_BITS - 1));
  assign ready_c   = (state_q == IDLE) || stop_last;
  assign accept    = valid && ready_c;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: ;
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shreg_d = shreg_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            stop_d = 1'b0;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
`endif
      STOP: begin
        if (stop_last) begin
          state_d = IDLE;
        end else if (bit_done) begin
          stop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = START;
      shreg_d = data_in;
`ifdef UART_TX_PARITY_EN
      par_d   = (^data_in) ^ 1'(PARITY_ODD);
`endif
    end

    // Line level for the cycle after this edge, registered so tx has no
    // combinational path from the inputs.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx    = tx_q;
  assign ready = ready_c;
  assign busy  = !ready_c;

endmodule
